// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, FSM states,
// error flags and small address/size helpers.
package mem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic LSU_ERR_NONE = 1'b0;
    localparam logic LSU_ERR      = 1'b1;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLdHi   = 3'd1,
        StStWr   = 3'd2,
        StStRdHi = 3'd3,
        StStWrHi = 3'd4,
        StResp   = 3'd5
    } lsu_state_e;

    // Unsigned load widths exist only on the load side.
    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: is_legal = 1'b1;
            F3_BU, F3_HU:     is_legal = ~we;
            default:          is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic is_cross(input logic [2:0] f3, input logic [1:0] off);
        is_cross = ((f3[1:0] == 2'b01) && (off == 2'b11)) ||
                   ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

    function automatic logic [31:0] word_addr(input logic [31:0] a);
        word_addr = {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Pipeline request/response handshake plus word-only data RAM port of the LSU.
interface mem_lsu_if;

    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_data_o;
    logic        resp_err_o;
    logic        ram_r_ena_o;
    logic [31:0] ram_r_addr_o;
    logic [31:0] ram_r_data_i;
    logic        ram_w_ena_o;
    logic [31:0] ram_w_addr_o;
    logic [31:0] ram_w_data_o;

    modport slave (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, ram_r_data_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_err_o,
        output ram_r_ena_o, ram_r_addr_o, ram_w_ena_o, ram_w_addr_o, ram_w_data_o
    );

    modport master (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, ram_r_data_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_err_o,
        input  ram_r_ena_o, ram_r_addr_o, ram_w_ena_o, ram_w_addr_o, ram_w_data_o
    );

endinterface

// File: rtl/mem_lsu_lane_merge.sv
// Byte-lane steering: extracts/extends load data from a {hi,lo} word pair and merges
// store bytes into an old word (lo or hi half of a possibly word-crossing access).
module mem_lsu_lane_merge
    import mem_lsu_pkg::*;
(
    input  logic [31:0] i_lo,
    input  logic [31:0] i_hi,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_ld_data,
    input  logic [31:0] i_old,
    input  logic [31:0] i_wdata,
    input  logic        i_hi_sel,
    output logic [31:0] o_st_data
);

    logic [31:0] w_win;
    logic [3:0]  w_size_mask;
    logic [7:0]  w_mask8;
    logic [63:0] w_data64;
    logic [3:0]  w_mask4;
    logic [31:0] w_new;

    always_comb begin
        w_win = 32'({i_hi, i_lo} >> {i_off, 3'b000});
        case (i_funct3)
            F3_B:    o_ld_data = {{24{w_win[7]}}, w_win[7:0]};
            F3_H:    o_ld_data = {{16{w_win[15]}}, w_win[15:0]};
            F3_W:    o_ld_data = w_win;
            F3_BU:   o_ld_data = {24'h0, w_win[7:0]};
            F3_HU:   o_ld_data = {16'h0, w_win[15:0]};
            default: o_ld_data = 32'h0;
        endcase
    end

    // Lanes 7:4 of the 64-bit view belong to the second (hi) word.
    always_comb begin
        case (i_funct3[1:0])
            2'b00:   w_size_mask = 4'b0001;
            2'b01:   w_size_mask = 4'b0011;
            2'b10:   w_size_mask = 4'b1111;
            default: w_size_mask = 4'b0000;
        endcase
        w_mask8  = {4'b0000, w_size_mask} << i_off;
        w_data64 = {32'h0, i_wdata} << {i_off, 3'b000};
        w_mask4  = i_hi_sel ? w_mask8[7:4] : w_mask8[3:0];
        w_new    = i_hi_sel ? w_data64[63:32] : w_data64[31:0];
        o_st_data = i_old;
        for (int i = 0; i < 4; i++) begin
            if (w_mask4[i]) o_st_data[8*i +: 8] = w_new[8*i +: 8];
        end
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: turns RV32I sub-word and misaligned accesses into
// word-only RAM reads/writes, stalling the pipeline while a sequence is in flight.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned SPLIT_EN = 1,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic        clk_100MHz,
    input  logic        arst_n,
    mem_lsu_if.slave    lsu
);

    lsu_state_e        r_state;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_word;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_resp_data;

    logic        w_idle;
    logic        w_accept;
    logic        w_req_cross;
    logic        w_req_err;
    logic        w_sw_direct;
    logic        w_cross_reg;
    logic [2:0]  w_f3;
    logic [1:0]  w_off;
    logic [31:0] w_addr_lo;
    logic [31:0] w_addr_hi;
    logic [31:0] w_ld_data;
    logic [31:0] w_st_data;
    logic        w_r_ena;
    logic [31:0] w_r_addr;
    logic        w_w_ena;
    logic [31:0] w_w_addr;
    logic [31:0] w_w_data;

    // Ready is gated by reset so no access leaks out while arst_n is low.
    assign w_idle      = (r_state == StIdle);
    assign w_accept    = lsu.req_valid_i & lsu.req_ready_o;
    assign w_req_cross = is_cross(lsu.req_funct3_i, lsu.req_addr_i[1:0]);
    assign w_req_err   = ~is_legal(lsu.req_we_i, lsu.req_funct3_i) |
                         (w_req_cross & (SPLIT_EN == 0));
    assign w_sw_direct = lsu.req_we_i & (lsu.req_funct3_i == F3_W) &
                         (lsu.req_addr_i[1:0] == 2'b00);
    assign w_cross_reg = is_cross(r_funct3, r_addr[1:0]);
    assign w_f3        = w_idle ? lsu.req_funct3_i : r_funct3;
    assign w_off       = w_idle ? lsu.req_addr_i[1:0] : r_addr[1:0];
    assign w_addr_lo   = word_addr(r_addr);
    assign w_addr_hi   = w_addr_lo + 32'd4;

    mem_lsu_lane_merge u_lane_merge (
        .i_lo      (w_idle ? lsu.ram_r_data_i : r_word),
        .i_hi      (lsu.ram_r_data_i),
        .i_off     (w_off),
        .i_funct3  (w_f3),
        .o_ld_data (w_ld_data),
        .i_old     (r_word),
        .i_wdata   (r_wdata),
        .i_hi_sel  (r_state == StStWrHi),
        .o_st_data (w_st_data)
    );

    always_comb begin
        w_r_ena  = 1'b0;
        w_r_addr = 32'h0;
        w_w_ena  = 1'b0;
        w_w_addr = 32'h0;
        w_w_data = 32'h0;
        case (r_state)
            StIdle: begin
                if (w_accept && !w_req_err) begin
                    if (w_sw_direct) begin
                        w_w_ena  = 1'b1;
                        w_w_addr = word_addr(lsu.req_addr_i);
                        w_w_data = lsu.req_wdata_i;
                    end else begin
                        w_r_ena  = 1'b1;
                        w_r_addr = word_addr(lsu.req_addr_i);
                    end
                end
            end
            StLdHi, StStRdHi: begin
                w_r_ena  = 1'b1;
                w_r_addr = w_addr_hi;
            end
            StStWr: begin
                w_w_ena  = 1'b1;
                w_w_addr = w_addr_lo;
                w_w_data = w_st_data;
            end
            StStWrHi: begin
                w_w_ena  = 1'b1;
                w_w_addr = w_addr_hi;
                w_w_data = w_st_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            r_state      <= StIdle;
            r_funct3     <= 3'h0;
            r_addr       <= '0;
            r_wdata      <= 32'h0;
            r_word       <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= LSU_ERR_NONE;
            r_resp_data  <= 32'h0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_funct3 <= lsu.req_funct3_i;
                        r_addr   <= lsu.req_addr_i;
                        r_wdata  <= lsu.req_wdata_i;
                        if (w_req_err) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= LSU_ERR;
                            r_state      <= StResp;
                        end else if (!lsu.req_we_i) begin
                            if (w_req_cross) begin
                                r_word  <= lsu.ram_r_data_i;
                                r_state <= StLdHi;
                            end else begin
                                r_resp_data  <= w_ld_data;
                                r_resp_valid <= 1'b1;
                                r_state      <= StResp;
                            end
                        end else if (w_sw_direct) begin
                            r_resp_valid <= 1'b1;
                            r_state      <= StResp;
                        end else begin
                            r_word  <= lsu.ram_r_data_i;
                            r_state <= StStWr;
                        end
                    end
                end
                StLdHi: begin
                    r_resp_data  <= w_ld_data;
                    r_resp_valid <= 1'b1;
                    r_state      <= StResp;
                end
                StStWr: begin
                    if (w_cross_reg) begin
                        r_state <= StStRdHi;
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_state      <= StResp;
                    end
                end
                StStRdHi: begin
                    r_word  <= lsu.ram_r_data_i;
                    r_state <= StStWrHi;
                end
                StStWrHi: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= StResp;
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= LSU_ERR_NONE;
                    r_resp_data  <= 32'h0;
                    r_state      <= StIdle;
                end
            endcase
        end
    end

    assign lsu.req_ready_o  = arst_n & w_idle;
    assign lsu.resp_valid_o = r_resp_valid;
    assign lsu.resp_err_o   = r_resp_err;
    assign lsu.resp_data_o  = r_resp_data;
    assign lsu.ram_r_ena_o  = w_r_ena;
    assign lsu.ram_r_addr_o = w_r_addr;
    assign lsu.ram_w_ena_o  = w_w_ena;
    assign lsu.ram_w_addr_o = w_w_addr;
    assign lsu.ram_w_data_o = w_w_data;

endmodule
